// File: rtl/chart_recorder_if.sv
// Playback port of chart_recorder.
// Carries one chart entry at a time in the same shape the ROM chart uses,
// so arrow_logic can read recorded steps in place of the ROM chart.
//   arrows : current entry arrows {L,U,D,R}
//   timing : current entry gap in ticks
//   valid  : arrows/timing hold a valid entry
//   next   : consumer asks for the following entry
// master = recorder side, slave = consumer side.
interface chart_recorder_if;
  logic [3:0] arrows;
  logic [3:0] timing;
  logic       valid;
  logic       next;

  modport master (output arrows, output timing, output valid, input next);
  modport slave  (input arrows, input timing, input valid, output next);
endinterface

// File: rtl/chart_recorder.sv
// chart_recorder: captures debounced step presses as {arrows, timing} chart
// entries quantised to frame-derived ticks, then replays them in a loop.
// Ports:
//   clk_i, rst_i        pixel clock, synchronous active-high reset
//   frame_i             one-cycle pulse at start of vertical blanking
//   record_i/play_i/stop_i  control pulses (record wins over play)
//   btn_*_i             one-cycle press pulses, arrow bits {L,U,D,R}
//   pb                  playback port (arrows, timing, valid, next)
//   recording_o         high while recording
//   full_o              chart memory full
//   count_o             number of stored entries (0..DEPTH)
module chart_recorder #(
  parameter int DEPTH       = 64,
  parameter int AW          = 6,
  parameter int TICK_FRAMES = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            frame_i,
  input  logic            record_i,
  input  logic            play_i,
  input  logic            stop_i,
  input  logic            btn_left_i,
  input  logic            btn_up_i,
  input  logic            btn_down_i,
  input  logic            btn_right_i,
  chart_recorder_if.master pb,
  output logic            recording_o,
  output logic            full_o,
  output logic [AW:0]     count_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    FLUSH  = 2'd2,
    PLAY   = 2'd3
  } state_t;

  localparam logic [7:0]  TICK_LAST = 8'(TICK_FRAMES - 1);
  localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);

  state_t        state;
  logic [7:0]    frame_cnt;
  logic [3:0]    pend;
  logic [3:0]    gap;
  logic [AW-1:0] rd_ptr;
  logic          load;      // memory data for rd_ptr lands in rd_data this cycle

  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data;

  logic [3:0]    btns;
  logic [3:0]    pend_next;
  logic          tick;
  logic          start_rec;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          advance;
  logic [AW-1:0] next_ptr;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] mem_addr;

  // Tick detection, write decision and the shared memory address.
  always_comb begin
    btns      = {btn_left_i, btn_up_i, btn_down_i, btn_right_i};
    pend_next = pend | btns;
    tick      = frame_i && (frame_cnt == TICK_LAST);
    start_rec = record_i && ((state == IDLE) || (state == PLAY));
    wr_en     = 1'b0;
    wr_data   = 8'h00;
    if ((state == RECORD) && tick) begin
      if (pend_next != 4'h0) begin
        // a press on the tick cycle itself belongs to this tick's entry
        wr_en   = !full_o;
        wr_data = {pend_next, gap};
      end else if (gap == 4'hE) begin
        // gap would reach 15: emit a rest entry instead of wrapping
        wr_en   = !full_o;
        wr_data = 8'h0F;
      end else begin
        wr_en   = 1'b0;
      end
    end else if ((state == FLUSH) && (pend != 4'h0)) begin
      wr_en   = !full_o;
      wr_data = {pend, gap};
    end else begin
      wr_en   = 1'b0;
    end

    // playback loops back to entry 0 after the last stored entry
    if (({1'b0, rd_ptr} + (AW+1)'(1)) == count_o) begin
      next_ptr = '0;
    end else begin
      next_ptr = rd_ptr + AW'(1);
    end

    advance = (state == PLAY) && !record_i && !stop_i && !load && pb.next && pb.valid;

    // outside PLAY the read port sits on entry 0 so a play pulse fetches it at once
    if (state != PLAY) begin
      rd_addr = '0;
    end else if (advance) begin
      rd_addr = next_ptr;
    end else begin
      rd_addr = rd_ptr;
    end

    if (wr_en) begin
      mem_addr = count_o[AW-1:0];
    end else begin
      mem_addr = rd_addr;
    end
  end

  // Single-port chart memory with synchronous read.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[mem_addr] <= wr_data;
    end else begin
      rd_data <= mem[mem_addr];
    end
  end

  // Control FSM, capture registers and registered playback outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      frame_cnt   <= 8'd0;
      pend        <= 4'h0;
      gap         <= 4'h0;
      rd_ptr      <= '0;
      load        <= 1'b0;
      count_o     <= '0;
      full_o      <= 1'b0;
      recording_o <= 1'b0;
      pb.arrows   <= 4'h0;
      pb.timing   <= 4'h0;
      pb.valid    <= 1'b0;
    end else if (start_rec) begin
      state       <= RECORD;
      frame_cnt   <= 8'd0;
      pend        <= 4'h0;
      gap         <= 4'h0;
      rd_ptr      <= '0;
      load        <= 1'b0;
      count_o     <= '0;
      full_o      <= 1'b0;
      recording_o <= 1'b1;
      pb.arrows   <= 4'h0;
      pb.timing   <= 4'h0;
      pb.valid    <= 1'b0;
    end else begin
      if (wr_en) begin
        count_o <= count_o + (AW+1)'(1);
        full_o  <= ((count_o + (AW+1)'(1)) == DEPTH_W);
      end
      case (state)
        IDLE: begin
          if (play_i && (count_o != '0)) begin
            state  <= PLAY;
            rd_ptr <= '0;
            load   <= 1'b1;
          end
        end
        RECORD: begin
          if (frame_i) begin
            frame_cnt <= tick ? 8'd0 : frame_cnt + 8'd1;
          end
          if (tick) begin
            if ((pend_next != 4'h0) || (gap == 4'hE)) begin
              pend <= 4'h0;
              gap  <= 4'h0;
            end else begin
              gap  <= gap + 4'h1;
            end
          end else begin
            pend <= pend_next;
          end
          if (stop_i) begin
            state       <= FLUSH;
            recording_o <= 1'b0;
          end
        end
        FLUSH: begin
          pend  <= 4'h0;
          gap   <= 4'h0;
          state <= IDLE;
        end
        PLAY: begin
          if (stop_i) begin
            state     <= IDLE;
            load      <= 1'b0;
            pb.arrows <= 4'h0;
            pb.timing <= 4'h0;
            pb.valid  <= 1'b0;
          end else if (load) begin
            load      <= 1'b0;
            pb.arrows <= rd_data[7:4];
            pb.timing <= rd_data[3:0];
            pb.valid  <= 1'b1;
          end else if (advance) begin
            rd_ptr    <= next_ptr;
            load      <= 1'b1;
            pb.arrows <= 4'h0;
            pb.timing <= 4'h0;
            pb.valid  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chart_recorder.sv
// Bench for chart_recorder: a 64-entry and a 4-entry instance share all
// stimulus. Expected charts come from a list of per-tick press masks.
module tb_chart_recorder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame = 1'b0, record = 1'b0, play = 1'b0, stop = 1'b0, next = 1'b0;
  logic [3:0] btn = 4'h0;

  logic       rec_big, full_big, rec_sm, full_sm;
  logic [6:0] cnt_big;
  logic [2:0] cnt_sm;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] mq[$];     // OR of presses seen in each tick window
  logic [7:0] exp_q[$];  // expected chart

  chart_recorder_if pb_big();
  chart_recorder_if pb_sm();
  assign pb_big.next = next;
  assign pb_sm.next  = next;

  always #5 clk = ~clk;

  chart_recorder #(.DEPTH(64), .AW(6), .TICK_FRAMES(2)) u_big (
    .clk_i(clk), .rst_i(rst), .frame_i(frame), .record_i(record), .play_i(play),
    .stop_i(stop), .btn_left_i(btn[3]), .btn_up_i(btn[2]), .btn_down_i(btn[1]),
    .btn_right_i(btn[0]), .pb(pb_big), .recording_o(rec_big), .full_o(full_big),
    .count_o(cnt_big));

  chart_recorder #(.DEPTH(4), .AW(2), .TICK_FRAMES(2)) u_sm (
    .clk_i(clk), .rst_i(rst), .frame_i(frame), .record_i(record), .play_i(play),
    .stop_i(stop), .btn_left_i(btn[3]), .btn_up_i(btn[2]), .btn_down_i(btn[1]),
    .btn_right_i(btn[0]), .pb(pb_sm), .recording_o(rec_sm), .full_o(full_sm),
    .count_o(cnt_sm));

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // Chart from tick masks: a pressed tick stores {mask, ticks since last entry};
  // 15 silent ticks in a row store a rest {0,F}; a trailing press flushes on stop.
  task automatic build_model(input logic [3:0] tail);
    int g;
    g = 0;
    exp_q.delete();
    foreach (mq[k]) begin
      if (mq[k] != 4'h0) begin
        exp_q.push_back({mq[k], 4'(g)});
        g = 0;
      end else if (g + 1 == 15) begin
        exp_q.push_back(8'h0F);
        g = 0;
      end else begin
        g = g + 1;
      end
    end
    if (tail != 4'h0) exp_q.push_back({tail, 4'(g)});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clk1(); clk1();
    n_checks++;
    if ({rec_big, full_big, cnt_big, pb_big.valid, pb_big.arrows, pb_big.timing} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_big: got rec=%b full=%b cnt=%0d v=%b a=%h t=%h, expected all 0",
               rec_big, full_big, cnt_big, pb_big.valid, pb_big.arrows, pb_big.timing);
    end
    n_checks++;
    if ({rec_sm, full_sm, cnt_sm, pb_sm.valid} !== 6'h0) begin
      n_fail++;
      $display("FAIL reset_small: got rec=%b full=%b cnt=%0d v=%b, expected all 0",
               rec_sm, full_sm, cnt_sm, pb_sm.valid);
    end
    rst = 1'b0;
    clk1();
  endtask

  // Drive one recording: each mq entry is a 6-cycle window with frames at
  // positions 2 and 5 (5 wraps the counter); each set bit is pressed once at
  // a random position, or on the wrapping frame when on_tick is set.
  task automatic do_record(input logic [3:0] tail, input bit tail_with_stop,
                           input bit on_tick, input bit check_full);
    int pos[4];
    int es;
    record = 1'b1; clk1(); record = 1'b0;
    n_checks++;
    if (rec_big !== 1'b1 || full_sm !== 1'b0) begin
      n_fail++;
      $display("FAIL record_start: got rec=%b full_sm=%b, expected rec=1 full_sm=0", rec_big, full_sm);
    end
    foreach (mq[k]) begin
      for (int b = 0; b < 4; b++) pos[b] = on_tick ? 5 : int'($urandom_range(0, 5));
      for (int c = 0; c < 6; c++) begin
        frame = (c == 2) || (c == 5);
        for (int b = 0; b < 4; b++) btn[b] = mq[k][b] && (pos[b] == c);
        clk1();
      end
      frame = 1'b0;
      btn = 4'h0;
    end
    build_model(tail);
    if (check_full) begin
      n_checks++;
      if (cnt_sm !== 3'd4 || full_sm !== 1'b1 || rec_sm !== 1'b1) begin
        n_fail++;
        $display("FAIL full_hold: got cnt=%0d full=%b rec=%b, expected cnt=4 full=1 rec=1",
                 cnt_sm, full_sm, rec_sm);
      end
    end
    clk1();
    btn = tail;
    stop = tail_with_stop;
    clk1();
    btn = 4'h0;
    if (!tail_with_stop) begin
      stop = 1'b1; clk1();
    end
    stop = 1'b0;
    clk1();  // flush cycle
    clk1();
    es = (exp_q.size() > 4) ? 4 : exp_q.size();
    n_checks++;
    if (cnt_big !== 7'(exp_q.size()) || rec_big !== 1'b0) begin
      n_fail++;
      $display("FAIL count_big: got cnt=%0d rec=%b, expected cnt=%0d rec=0", cnt_big, rec_big, exp_q.size());
    end
    n_checks++;
    if (cnt_sm !== 3'(es) || full_sm !== (exp_q.size() >= 4) || rec_sm !== 1'b0) begin
      n_fail++;
      $display("FAIL count_small: got cnt=%0d full=%b rec=%b, expected cnt=%0d full=%b rec=0",
               cnt_sm, full_sm, rec_sm, es, exp_q.size() >= 4);
    end
  endtask

  // Play the big instance through one full loop plus one wrapped entry.
  task automatic test_playback();
    int n;
    n = exp_q.size();
    play = 1'b1; clk1(); play = 1'b0;
    if (n == 0) begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (pb_big.valid !== 1'b0) begin
          n_fail++;
          $display("FAIL play_empty: got valid=%b, expected 0", pb_big.valid);
        end
        clk1();
      end
      return;
    end
    n_checks++;
    if (pb_big.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL play_latency: got valid=%b one cycle after play, expected 0", pb_big.valid);
    end
    next = 1'b1;  // valid is low here, so this must not move the pointer
    clk1();
    next = 1'b0;
    for (int i = 0; i <= n; i++) begin
      n_checks++;
      if (pb_big.valid !== 1'b1 || {pb_big.arrows, pb_big.timing} !== exp_q[i % n]) begin
        n_fail++;
        $display("FAIL play_entry%0d: got valid=%b entry=%h, expected valid=1 entry=%h",
                 i, pb_big.valid, {pb_big.arrows, pb_big.timing}, exp_q[i % n]);
      end
      next = 1'b1; clk1();
      next = 1'($urandom_range(0, 1));
      n_checks++;
      if (pb_big.valid !== 1'b0) begin
        n_fail++;
        $display("FAIL next_gap%0d: got valid=%b, expected 0", i, pb_big.valid);
      end
      clk1();
      next = 1'b0;
    end
    stop = 1'b1; clk1(); stop = 1'b0;
    n_checks++;
    if (pb_big.valid !== 1'b0 || pb_big.arrows !== 4'h0 || pb_big.timing !== 4'h0) begin
      n_fail++;
      $display("FAIL play_stop: got valid=%b a=%h t=%h, expected 0 0 0",
               pb_big.valid, pb_big.arrows, pb_big.timing);
    end
  endtask

  task automatic test_reset_mid_record();
    record = 1'b1; clk1(); record = 1'b0;
    btn = 4'b0100; clk1(); btn = 4'h0;
    frame = 1'b1; clk1(); frame = 1'b0;
    rst = 1'b1; clk1(); rst = 1'b0;
    n_checks++;
    if ({rec_big, full_big, cnt_big, pb_big.valid, pb_big.arrows, pb_big.timing} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_mid_record: got rec=%b cnt=%0d v=%b, expected all 0", rec_big, cnt_big, pb_big.valid);
    end
    mq.delete();
    build_model(4'h0);
    test_playback();
  endtask

  task automatic test_basic();
    mq = '{4'b0100, 4'b0000, 4'b1001};
    do_record(4'h0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cnt_big !== 7'd2) begin
      n_fail++;
      $display("FAIL basic_count: got %0d, expected 2", cnt_big);
    end
    test_playback();
  endtask

  task automatic test_press_on_tick();
    mq = '{4'b0000, 4'b0010};
    do_record(4'h0, 1'b0, 1'b1, 1'b0);
    test_playback();
  endtask

  task automatic test_rest();
    mq.delete();
    for (int i = 0; i < 30; i++) mq.push_back(4'h0);
    do_record(4'h0, 1'b0, 1'b0, 1'b0);
    test_playback();
  endtask

  task automatic test_full();
    mq.delete();
    for (int i = 0; i < 6; i++) mq.push_back(4'($urandom_range(1, 15)));
    do_record(4'h0, 1'b0, 1'b0, 1'b1);
    test_playback();
  endtask

  task automatic test_flush();
    mq = '{4'b0001, 4'b0000, 4'b0000};
    do_record(4'b1010, 1'b1, 1'b0, 1'b0);
    test_playback();
  endtask

  task automatic test_record_and_play();
    record = 1'b1; play = 1'b1; clk1(); record = 1'b0; play = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rec_big !== 1'b1 || pb_big.valid !== 1'b0) begin
        n_fail++;
        $display("FAIL record_wins: got rec=%b valid=%b, expected rec=1 valid=0", rec_big, pb_big.valid);
      end
      clk1();
    end
    stop = 1'b1; clk1(); stop = 1'b0; clk1();
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      mq.delete();
      for (int i = 0; i < int'($urandom_range(3, 20)); i++)
        mq.push_back($urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0);
      do_record(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      test_playback();
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_record();
    test_basic();
    test_press_on_tick();
    test_rest();
    test_full();
    test_flush();
    test_record_and_play();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/chart_recorder.md
Name: chart_recorder

Overview:
Records player step input into an on-chip chart memory, then plays it back.
- Capture: samples debounced left/up/down/right press pulses, quantises them to tick boundaries derived from frame_i, and stores them as {arrows, timing} entries.
- Playback: presents stored entries through an arrows/timing/next interface in the same format chart produces, so arrow_logic can consume a recorded chart in place of the ROM chart.
- Sits in the clk_pix domain beside chart.

Parameters:
DEPTH, 64, number of chart entries; power of two.
AW, 6, address width; DEPTH = 2**AW.
TICK_FRAMES, 8, frames per timing unit; legal range 1..255.

Ports:
clk_i  input  1  pixel clock; all logic on rising edge
rst_i  input  1  synchronous active-high reset
frame_i  input  1  one-cycle pulse at start of vertical blanking
record_i  input  1  pulse: clear memory and start recording
play_i  input  1  pulse: start playback from entry 0
stop_i  input  1  pulse: end recording or playback
btn_left_i  input  1  one-cycle press pulse (arrow bit 3)
btn_up_i  input  1  one-cycle press pulse (arrow bit 2)
btn_down_i  input  1  one-cycle press pulse (arrow bit 1)
btn_right_i  input  1  one-cycle press pulse (arrow bit 0)
next_i  input  1  playback advance request
arrows_o  output  4  current playback arrows {L,U,D,R}
timing_o  output  4  current playback gap in ticks
valid_o  output  1  arrows_o/timing_o hold a valid entry
recording_o  output  1  high in RECORD
full_o  output  1  count == DEPTH
count_o  output  AW+1  number of stored entries

Behaviour:
- Reset: state IDLE; arrows_o=0, timing_o=0, valid_o=0, recording_o=0, full_o=0, count_o=0.
- Reset does not need to clear memory contents; count_o=0 makes them unreachable.
- Reset mid-record or mid-play aborts immediately.
- States:
  - IDLE: play_i with count_o>0 -> PLAY; play_i with count_o==0 -> stay IDLE.
  - IDLE or PLAY: record_i -> RECORD.
  - record_i and play_i asserted together: record_i wins.
  - RECORD: stop_i -> FLUSH -> IDLE.
  - PLAY: stop_i -> IDLE.
- Tick generator:
  - Frame counter counts frame_i pulses 0..TICK_FRAMES-1.
  - A tick occurs on the frame_i pulse that wraps the counter.
  - The counter is cleared on entry to RECORD.
- Recording:
  - Entering RECORD clears count_o, the pending arrow register (pend), and the gap counter (gap).
  - Each button pulse ORs its bit into pend. A press on the tick cycle is included in that tick's entry.
  - On a tick with pend!=0: write {pend, gap} at address count_o, count_o+1, then pend=0, gap=0.
  - On a tick with pend==0: gap+1.
  - If gap would reach 15, write a rest entry {4'b0000, 4'hF} and set gap=0.
  - Entry byte layout: [7:4]=arrows, [3:0]=timing.
  - Full (count_o==DEPTH): writes are dropped, full_o=1, and the state stays RECORD until stop_i.
  - full_o clears only on a new record_i.
- FLUSH: one cycle. If pend!=0 and not full, write {pend, gap}. Then go to IDLE.
- Playback:
  - Entering PLAY sets rd_ptr=0 and issues a registered memory read.
  - Entry 0 appears on arrows_o/timing_o with valid_o=1 two cycles after play_i.
  - next_i with valid_o=1 at cycle t: valid_o=0 at t+1; the next entry appears with valid_o=1 at t+2.
  - next_i while valid_o=0 is ignored.
  - rd_ptr wraps from count_o-1 to 0, so playback loops.
  - Outside PLAY: valid_o=0, arrows_o=0, timing_o=0.
- Memory: single-port DEPTH x 8 with a synchronous read; inferable as iCE40 EBR. Reads and writes never occur in the same state.
- Widths: gap is 4 bits and saturates via the rest-entry rule, never by wrapping. count_o is AW+1 bits so it can represent DEPTH.

Test Plan:
- Reset mid-record: TICK_FRAMES=2; record_i, one press, assert rst_i -> all outputs 0, state IDLE; a following play_i leaves valid_o=0.
- Basic capture and playback: TICK_FRAMES=2; record_i; btn_up_i before the 2nd frame_i; btn_left_i and btn_right_i before the 6th frame_i; stop_i; play_i.
  - count_o=2.
  - First entry: arrows_o=4'b0100, timing_o=0.
  - After next_i: arrows_o=4'b1001, timing_o=1.
  - Another next_i wraps back to the first entry.
- Simultaneous press and tick: btn_down_i on the exact cycle of the wrapping frame_i -> entry {0010, gap} written at that tick, not the next.
- Rest entry: record with no presses for 30 ticks -> count_o=2, both entries {0000, 1111}.
- Full: DEPTH=4; press every tick for 6 ticks -> count_o=4, full_o=1, recording_o=1; stop_i -> IDLE, count_o stays 4.
- Flush on stop: press with stop_i before the next tick -> entry {pend, gap} stored, count_o+1.
- record_i and play_i in the same cycle -> recording_o=1, valid_o=0.
- next_i during valid_o=0 -> rd_ptr unchanged.
